// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and constants for the regfile_sweep register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int c_def_width = 32;
    localparam int c_def_depth = 32;

    // Address width for a given depth; a depth below 2 still gets one bit.
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clear_seq.sv
// ============================================================================
// Module   : regfile_clear_seq
// Purpose  : CLEAR/RUN sequencer that sweeps zeroes through every entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = c_def_depth,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              ready
);

    // One spare bit so the terminal compare never aliases on wrap.
    localparam logic [ADDR_W:0] c_last = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] c_one  = (ADDR_W + 1)'(1);

    state_t            state_q;
    logic [ADDR_W:0]   cnt_q;
    logic              ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (clr) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == CLEAR) begin
            if (cnt_q == c_last) begin
                state_q <= RUN;
                cnt_q   <= '0;
                ready_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + c_one;
            end
        end
    end

    assign sweep_we   = (state_q == CLEAR);
    assign sweep_addr = cnt_q[ADDR_W-1:0];
    assign ready      = ready_q;

endmodule

`default_nettype wire

// File: rtl/regfile_sweep.sv
// ============================================================================
// Module   : regfile_sweep
// Purpose  : 2R/1W register file, registered reads, hardware clear sweep.
//            Macro REGFILE_BYPASS_EN selects write-first read bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sweep
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = c_def_width,
    parameter int  DEPTH    = c_def_depth,
    parameter int  ZERO_REG = 1,
    localparam int ADDR_W   = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] Aw,
    input  logic [WIDTH-1:0]  Dw,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    output logic [WIDTH-1:0]  Da,
    output logic [WIDTH-1:0]  Db,
    output logic              ready
);

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              zero_wr;
    logic              wr_go;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  da_d, db_d;
    logic [WIDTH-1:0]  da_q, db_q;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .ready      (ready)
    );

    assign zero_wr = (ZERO_REG != 0) && (Aw == '0);
    assign wr_go   = WrEn && !sweep_we && !zero_wr;

    // Array has no reset; the sweep owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[sweep_addr] <= '0;
        end else if (wr_go) begin
            mem_q[Aw] <= Dw;
        end
    end

    always_comb begin
        da_d = mem_q[Rs];
        db_d = mem_q[Rt];
`ifdef REGFILE_BYPASS_EN
        if (wr_go && (Aw == Rs)) da_d = Dw;
        if (wr_go && (Aw == Rt)) db_d = Dw;
`endif
        if ((ZERO_REG != 0) && (Rs == '0)) da_d = '0;
        if ((ZERO_REG != 0) && (Rt == '0)) db_d = '0;
        if (sweep_we) begin
            da_d = '0;
            db_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            da_q <= '0;
            db_q <= '0;
        end else begin
            da_q <= da_d;
            db_q <= db_d;
        end
    end

    assign Da = da_q;
    assign Db = db_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sweep.sv
// ============================================================================
// Module   : tb_regfile_sweep
// Purpose  : Scoreboard bench for regfile_sweep (ZERO_REG=1 and ZERO_REG=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sweep;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        WrEn;
    logic [4:0]  Aw, Rs, Rt;
    logic [31:0] Dw;
    logic [31:0] Da, Db, Da0, Db0;
    logic        ready, ready0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          due;
        logic        er;
        logic        chk;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ea0;
        logic [31:0] eb0;
    } exp_t;

    exp_t  sq[$];
    string nq[$];
    exp_t  e;
    string nm;
    bit    bad;

    regfile_sweep u_dut (
        .clk (clk), .reset (reset), .clr (clr), .WrEn (WrEn),
        .Aw (Aw), .Dw (Dw), .Rs (Rs), .Rt (Rt),
        .Da (Da), .Db (Db), .ready (ready)
    );

    regfile_sweep #(.ZERO_REG(0)) u_dut_nz (
        .clk (clk), .reset (reset), .clr (clr), .WrEn (WrEn),
        .Aw (Aw), .Dw (Dw), .Rs (Rs), .Rt (Rt),
        .Da (Da0), .Db (Db0), .ready (ready0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation whose result is now on the outputs.
    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            e  = sq.pop_front();
            nm = nq.pop_front();
            bad = 1'b0;
            if (ready !== e.er || ready0 !== e.er) bad = 1'b1;
            if (e.chk && (Da !== e.ea || Db !== e.eb || Da0 !== e.ea0 || Db0 !== e.eb0))
                bad = 1'b1;
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got ready=%b/%b Da=%h Db=%h Da0=%h Db0=%h, want ready=%b Da=%h Db=%h Da0=%h Db0=%h (data checked=%b)",
                         nm, cyc, ready, ready0, Da, Db, Da0, Db0,
                         e.er, e.ea, e.eb, e.ea0, e.eb0, e.chk);
            end
        end
    end

    task automatic issue(input string n, input logic we, input logic [4:0] aw,
                         input logic [31:0] dw, input logic [4:0] rs, input logic [4:0] rt,
                         input logic c, input logic chk, input logic er,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ea0, input logic [31:0] eb0);
        exp_t x;
        WrEn = we; Aw = aw; Dw = dw; Rs = rs; Rt = rt; clr = c;
        x.due = cyc + 1; x.er = er; x.chk = chk;
        x.ea = ea; x.eb = eb; x.ea0 = ea0; x.eb0 = eb0;
        sq.push_back(x);
        nq.push_back(n);
        @(negedge clk);
    endtask

    // 32 cycles after a restart edge: ready low until the final sweep write.
    task automatic expect_sweep(input string n);
        for (int k = 1; k <= 32; k++)
            issue(n, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b0, 1'b1, (k == 32), 0, 0, 0, 0);
    endtask

    task automatic check_now(input string n);
        n_tests++;
        if (Da !== 0 || Db !== 0 || ready !== 1'b0 || Da0 !== 0 || Db0 !== 0 || ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got Da=%h Db=%h ready=%b Da0=%h Db0=%h ready0=%b, want all zero",
                     n, Da, Db, ready, Da0, Db0, ready0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clr = 1'b0; WrEn = 1'b0;
        Aw = '0; Dw = '0; Rs = '0; Rt = '0;
        repeat (3) @(negedge clk);
        check_now("reset_state");
        reset = 1'b0;
        expect_sweep("init_sweep");

        for (int i = 1; i < 32; i++)
            issue("read_cleared", 1'b0, 5'd0, 0, 5'(i), 5'(i), 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);

        issue("wr_r5",      1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        issue("rd_r5",      1'b0, 5'd0, 0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1,
              32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        issue("wr_r0",      1'b1, 5'd0, 32'hFFFFFFFF, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        issue("rd_r0",      1'b0, 5'd0, 0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1,
              0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF);
        issue("wr_r7_1",    1'b1, 5'd7, 32'h1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1,
              32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        issue("same_cyc_rs", 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd5, 1'b0, 1'b1, 1'b1,
              c_byp ? 32'h12345678 : 32'h1, 32'hDEADBEEF,
              c_byp ? 32'h12345678 : 32'h1, 32'hDEADBEEF);
        issue("rd_r7",      1'b0, 5'd0, 0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1,
              32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
        issue("byp_r0",     1'b1, 5'd0, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1,
              0, 0, c_byp ? 32'hCAFEF00D : 32'hFFFFFFFF, c_byp ? 32'hCAFEF00D : 32'hFFFFFFFF);
        issue("same_cyc_rt", 1'b1, 5'd9, 32'h9, 5'd5, 5'd9, 1'b0, 1'b1, 1'b1,
              32'hDEADBEEF, c_byp ? 32'h9 : 32'h0, 32'hDEADBEEF, c_byp ? 32'h9 : 32'h0);
        issue("rd_r9_r0",   1'b0, 5'd0, 0, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1,
              32'h9, 0, 32'h9, 32'hCAFEF00D);

        issue("wr_r3",      1'b1, 5'd3, 32'hA5A5A5A5, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1,
              32'h9, 32'h9, 32'h9, 32'h9);
        issue("rd_r3",      1'b0, 5'd0, 0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1,
              32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        issue("clr_pulse",  1'b0, 5'd0, 0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            issue("clr_sweep", 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        issue("clr_restart", 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        expect_sweep("clr_sweep_full");
        issue("rd_r3_clr",  1'b0, 5'd0, 0, 5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);

        issue("wr_r3_33",   1'b1, 5'd3, 32'h33, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        issue("rd_r3_33",   1'b0, 5'd0, 0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1,
              32'h33, 32'h33, 32'h33, 32'h33);
        #2 reset = 1'b1;
        #1 check_now("async_reset_run");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++)
            issue("part_sweep", 1'b0, 5'd0, 0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1 check_now("async_reset_sweep");
        @(negedge clk);
        reset = 1'b0;
        expect_sweep("reset_sweep_full");
        issue("rd_r3_final", 1'b0, 5'd0, 0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        if (sq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
